// File: rtl/alarm_scheduler_if.sv
// -----------------------------------------------------------------------------
// alarm_scheduler_if
// Host-side bundle for the alarm scheduler: global enable, shared time
// counter, slot write port, missed-flag clear, and the irq/ack delivery
// handshake together with the status vectors.
//   master : host / timer subsystem side (drives *_i, observes *_o)
//   slave  : alarm_scheduler side (observes *_i, drives *_o)
// -----------------------------------------------------------------------------
interface alarm_scheduler_if #(
  parameter int NUM_ALARMS = 4,
  parameter int IDX_W      = $clog2(NUM_ALARMS)
);
  logic                  en_i;
  logic [31:0]           counter_i;
  logic                  wr_en_i;
  logic [IDX_W-1:0]      wr_idx_i;
  logic                  wr_enable_i;
  logic [31:0]           wr_time_i;
  logic [31:0]           wr_period_i;
  logic                  clr_missed_i;
  logic                  ack_i;
  logic                  irq_o;
  logic [IDX_W-1:0]      irq_id_o;
  logic [NUM_ALARMS-1:0] pending_o;
  logic [NUM_ALARMS-1:0] missed_o;
  logic [NUM_ALARMS-1:0] active_o;

  modport master (
    output en_i, counter_i, wr_en_i, wr_idx_i, wr_enable_i, wr_time_i,
           wr_period_i, clr_missed_i, ack_i,
    input  irq_o, irq_id_o, pending_o, missed_o, active_o
  );

  modport slave (
    input  en_i, counter_i, wr_en_i, wr_idx_i, wr_enable_i, wr_time_i,
           wr_period_i, clr_missed_i, ack_i,
    output irq_o, irq_id_o, pending_o, missed_o, active_o
  );
endinterface

// File: rtl/alarm_scheduler.sv
// -----------------------------------------------------------------------------
// alarm_scheduler
// NUM_ALARMS programmable alarm slots compared against a shared 32-bit
// free-running counter. Each slot is one-shot (period 0) or periodic with
// automatic reload. Matches become pending events (or set a sticky missed
// flag if one is already pending) and are delivered one at a time over a
// round-robin irq/ack handshake.
// Ports:
//   clk_i  : clock, all logic on the rising edge
//   rst_i  : synchronous active-high reset
//   bus    : alarm_scheduler_if.slave (enable, counter, slot write port,
//            missed clear, irq/ack handshake, pending/missed/active status)
// -----------------------------------------------------------------------------
module alarm_scheduler #(
  parameter int NUM_ALARMS = 4,
  parameter int IDX_W      = $clog2(NUM_ALARMS)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  alarm_scheduler_if.slave   bus
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FIRE = 1'b1
  } state_e;

  localparam logic [IDX_W:0]   NUM_W    = (IDX_W+1)'(NUM_ALARMS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ALARMS - 1);

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      rr_q, rr_d;
  logic [IDX_W-1:0]      irq_id_q, irq_id_d;

  logic [NUM_ALARMS-1:0] enable_vec;
  logic [NUM_ALARMS-1:0] pending_vec;
  logic [NUM_ALARMS-1:0] missed_vec;

  // The acknowledged event is consumed on the ack edge.
  logic                  ack_fire;
  assign ack_fire = (state_q == ST_FIRE) && bus.ack_i;

  // ---------------------------------------------------------------------------
  // Per-slot registers and match/reload logic
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_ALARMS; gi++) begin : g_slot
    logic        enable_q, enable_d;
    logic        pending_q, pending_d;
    logic        missed_q, missed_d;
    logic [31:0] alarm_time_q, alarm_time_d;
    logic [31:0] period_q, period_d;
    logic        wr_hit;
    logic        match;
    logic        ack_clr;

    // Out-of-range write indices never equal any slot number, so they
    // are dropped here without extra logic.
    assign wr_hit  = bus.wr_en_i && (bus.wr_idx_i == IDX_W'(gi));
    assign match   = bus.en_i && enable_q && (bus.counter_i == alarm_time_q) && !wr_hit;
    assign ack_clr = ack_fire && (irq_id_q == IDX_W'(gi));

    always_comb begin
      enable_d     = enable_q;
      pending_d    = pending_q;
      missed_d     = bus.clr_missed_i ? 1'b0 : missed_q;
      alarm_time_d = alarm_time_q;
      period_d     = period_q;
      if (wr_hit) begin
        enable_d     = bus.wr_enable_i;
        alarm_time_d = bus.wr_time_i;
        period_d     = bus.wr_period_i;
        pending_d    = 1'b0;
        missed_d     = 1'b0;
      end else begin
        // An ack on this slot retires the old event first, so a match in
        // the same cycle becomes a fresh pending event rather than a miss.
        pending_d = pending_q & ~ack_clr;
        if (match) begin
          if (pending_d) begin
            missed_d = 1'b1;
          end else begin
            pending_d = 1'b1;
          end
          if (period_q != 32'd0) begin
            alarm_time_d = alarm_time_q + period_q;
          end else begin
            enable_d = 1'b0;
          end
        end
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        enable_q     <= 1'b0;
        pending_q    <= 1'b0;
        missed_q     <= 1'b0;
        alarm_time_q <= 32'd0;
        period_q     <= 32'd0;
      end else begin
        enable_q     <= enable_d;
        pending_q    <= pending_d;
        missed_q     <= missed_d;
        alarm_time_q <= alarm_time_d;
        period_q     <= period_d;
      end
    end

    assign enable_vec[gi]  = enable_q;
    assign pending_vec[gi] = pending_q;
    assign missed_vec[gi]  = missed_q;
  end

  // ---------------------------------------------------------------------------
  // Round-robin selection: rotate pending so the rr pointer lands on bit 0,
  // find the lowest set bit, then rotate the offset back into a slot index.
  // ---------------------------------------------------------------------------
  logic [2*NUM_ALARMS-1:0] dbl_pending;
  logic [NUM_ALARMS-1:0]   rot_pending;
  logic [IDX_W:0]          sel_off;
  logic [IDX_W:0]          sel_sum;
  logic [IDX_W-1:0]        sel_idx;

  assign dbl_pending = {pending_vec, pending_vec} >> rr_q;
  assign rot_pending = dbl_pending[NUM_ALARMS-1:0];

  always_comb begin
    sel_off = '0;
    // Descending scan so the lowest set offset is the one left standing.
    for (int k = NUM_ALARMS - 1; k >= 0; k--) begin
      if (rot_pending[k]) begin
        sel_off = (IDX_W+1)'(k);
      end
    end
    sel_sum = {1'b0, rr_q} + sel_off;
    sel_idx = (sel_sum >= NUM_W) ? IDX_W'(sel_sum - NUM_W) : IDX_W'(sel_sum);
  end

  // ---------------------------------------------------------------------------
  // Delivery FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    irq_id_d = irq_id_q;
    rr_d     = rr_q;
    case (state_q)
      ST_IDLE: begin
        if (|pending_vec) begin
          irq_id_d = sel_idx;
          state_d  = ST_FIRE;
        end
      end
      ST_FIRE: begin
        if (bus.ack_i) begin
          state_d = ST_IDLE;
          rr_d    = (irq_id_q == LAST_IDX) ? '0 : irq_id_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      rr_q     <= '0;
      irq_id_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      irq_id_q <= irq_id_d;
    end
  end

  assign bus.irq_o     = (state_q == ST_FIRE);
  assign bus.irq_id_o  = irq_id_q;
  assign bus.pending_o = pending_vec;
  assign bus.missed_o  = missed_vec;
  assign bus.active_o  = enable_vec;

endmodule

// File: tb/tb_alarm_scheduler.sv
// -----------------------------------------------------------------------------
// tb_alarm_scheduler
// Directed scenarios (one-shot, periodic wrap, round-robin, missed, write
// collision, reset during delivery) followed by randomized traffic. Every
// cycle the outputs are compared with a behavioural model that keeps each
// slot as plain arrays and applies the alarm rules with ordinary arithmetic.
// -----------------------------------------------------------------------------
module tb_alarm_scheduler;
  localparam int N  = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alarm_scheduler_if #(.NUM_ALARMS(N)) bus ();

  alarm_scheduler #(.NUM_ALARMS(N)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit        m_en [N];
  bit [31:0] m_tm [N];
  bit [31:0] m_pr [N];
  bit        m_pd [N];
  bit        m_ms [N];
  bit        m_irq;
  int        m_id;
  int        m_rr;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_en[i] = 0; m_tm[i] = 0; m_pr[i] = 0; m_pd[i] = 0; m_ms[i] = 0;
    end
    m_irq = 0; m_id = 0; m_rr = 0;
  endfunction

  function automatic void model_edge();
    bit p [N];
    bit acked;
    int id0;
    if (rst) begin
      model_reset();
      return;
    end
    p     = m_pd;
    acked = m_irq && bus.ack_i;
    id0   = m_id;
    for (int i = 0; i < N; i++) begin
      if (bus.wr_en_i && int'(bus.wr_idx_i) == i) begin
        m_en[i] = bus.wr_enable_i;
        m_tm[i] = bus.wr_time_i;
        m_pr[i] = bus.wr_period_i;
        m_pd[i] = 0;
        m_ms[i] = 0;
      end else begin
        if (bus.clr_missed_i) m_ms[i] = 0;
        if (acked && id0 == i) m_pd[i] = 0;
        if (bus.en_i && m_en[i] && bus.counter_i == m_tm[i]) begin
          if (m_pd[i]) m_ms[i] = 1;
          else         m_pd[i] = 1;
          if (m_pr[i] != 0) m_tm[i] = m_tm[i] + m_pr[i];
          else              m_en[i] = 0;
        end
      end
    end
    if (m_irq) begin
      if (bus.ack_i) begin
        m_irq = 0;
        m_rr  = (id0 + 1) % N;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (p[(m_rr + k) % N]) begin
          m_irq = 1;
          m_id  = (m_rr + k) % N;
          break;
        end
      end
    end
  endfunction

  task automatic compare_all();
    logic [N-1:0] ep, em, ea;
    for (int i = 0; i < N; i++) begin
      ep[i] = m_pd[i]; em[i] = m_ms[i]; ea[i] = m_en[i];
    end
    chk("irq",     32'(bus.irq_o),     32'(m_irq));
    chk("irq_id",  32'(bus.irq_id_o),  m_id);
    chk("pending", 32'(bus.pending_o), 32'(ep));
    chk("missed",  32'(bus.missed_o),  32'(em));
    chk("active",  32'(bus.active_o),  32'(ea));
  endtask

  // ---------------- stimulus helpers ----------------
  bit auto_ack  = 0;
  bit rand_mode = 0;
  int delivered [$];

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
    bus.wr_en_i      = 0;
    bus.clr_missed_i = 0;
    bus.counter_i    = bus.counter_i + 32'd1;
    bus.ack_i        = rand_mode ? 1'($urandom_range(0, 1)) : (auto_ack && bus.irq_o);
    if (bus.ack_i && bus.irq_o) delivered.push_back(int'(bus.irq_id_o));
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic wr(input int idx, input bit e, input logic [31:0] t, input logic [31:0] p);
    bus.wr_en_i     = 1;
    bus.wr_idx_i    = IW'(idx);
    bus.wr_enable_i = e;
    bus.wr_time_i   = t;
    bus.wr_period_i = p;
    cyc();
  endtask

  task automatic do_reset();
    rst = 1;
    cyc();
    rst = 0;
  endtask

  function automatic int dq(input int k);
    return (delivered.size() > k) ? delivered[k] : -1;
  endfunction

  initial begin
    rst = 1;
    bus.en_i = 1; bus.counter_i = 0; bus.wr_en_i = 0; bus.wr_idx_i = 0;
    bus.wr_enable_i = 0; bus.wr_time_i = 0; bus.wr_period_i = 0;
    bus.clr_missed_i = 0; bus.ack_i = 0;
    do_reset();
    chk("reset_irq", 32'(bus.irq_o), 0);
    chk("reset_pending", 32'(bus.pending_o), 0);

    // One-shot slot 0 at time 100
    auto_ack = 1;
    bus.counter_i = 90;
    delivered.delete();
    wr(0, 1, 100, 0);
    run(16);
    chk("oneshot_count", delivered.size(), 1);
    chk("oneshot_id", dq(0), 0);
    chk("oneshot_active", 32'(bus.active_o[0]), 0);

    // Periodic slot 1 across the counter wrap
    bus.counter_i = 32'hFFFF_FFFA;
    delivered.delete();
    wr(1, 1, 32'hFFFF_FFFE, 4);
    run(10);
    chk("wrap_count", delivered.size(), 2);
    chk("wrap_id0", dq(0), 1);
    chk("wrap_id1", dq(1), 1);
    run(4);
    chk("wrap_reload6", delivered.size(), 3);
    wr(1, 0, 0, 0);

    // Round-robin across slots 0, 2, 3
    do_reset();
    for (int pass = 0; pass < 2; pass++) begin
      bus.counter_i = 40;
      delivered.delete();
      wr(0, 1, 50, 0);
      wr(2, 1, 50, 0);
      wr(3, 1, 50, 0);
      run(20);
      chk("rr_count", delivered.size(), 3);
      chk("rr_first", dq(0), 0);
      chk("rr_second", dq(1), 2);
      chk("rr_third", dq(2), 3);
    end

    // Missed events on slot 2, host never acks
    do_reset();
    auto_ack = 0;
    bus.counter_i = 10;
    wr(2, 1, 20, 3);
    run(14);
    chk("missed_set", 32'(bus.missed_o[2]), 1);
    chk("missed_pend", 32'(bus.pending_o[2]), 1);
    bus.clr_missed_i = 1;
    cyc();
    chk("missed_clr", 32'(bus.missed_o[2]), 0);
    run(2);
    chk("missed_again", 32'(bus.missed_o[2]), 1);

    // Reset while an irq is outstanding
    chk("fire_before_rst", 32'(bus.irq_o), 1);
    rst = 1;
    cyc();
    rst = 0;
    chk("rst_irq", 32'(bus.irq_o), 0);
    chk("rst_pending", 32'(bus.pending_o), 0);
    chk("rst_active", 32'(bus.active_o), 0);
    run(10);
    chk("rst_no_irq", 32'(bus.irq_o), 0);

    // Write colliding with a match on slot 0
    auto_ack = 1;
    bus.counter_i = 100;
    wr(0, 1, 105, 0);
    run(4);
    wr(0, 1, 200, 7);
    chk("collide_pend", 32'(bus.pending_o[0]), 0);
    chk("collide_active", 32'(bus.active_o[0]), 1);
    run(3);

    // Randomized traffic
    do_reset();
    rand_mode = 1;
    for (int c = 0; c < 3000; c++) begin
      bus.en_i = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) begin
        int pr;
        case ($urandom_range(0, 4))
          0: pr = 0;
          1: pr = 1;
          2: pr = 2;
          3: pr = 3;
          default: pr = 7;
        endcase
        bus.wr_en_i     = 1;
        bus.wr_idx_i    = IW'($urandom_range(0, N - 1));
        bus.wr_enable_i = ($urandom_range(0, 4) != 0);
        bus.wr_time_i   = bus.counter_i + 32'($urandom_range(0, 12));
        bus.wr_period_i = 32'(pr);
      end
      if ($urandom_range(0, 19) == 0) bus.clr_missed_i = 1;
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
